// File: rtl/prefetch_pc_gen.sv
// rtl/prefetch_pc_gen.sv - pre-fetch PC generator with ICache request tracking
//
// Selects the next fetch-group PC (eret > exception > branch redirect >
// BPU prediction > sequential), issues an aligned ICache request and tracks
// an outstanding request across an ICache miss so that a redirect arriving
// mid-miss replays the new PC and tells IF to discard the stale response.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   fs_allowin                    IF stage can accept a group
//   icache_busy                   ICache servicing a miss/refill
//   eret_valid/eret_pc            eret commit and EPC target
//   ex_flush                      exception commit, target EX_PC
//   br_redirect/br_target         branch misprediction and corrected PC
//   bpu_valid/bpu_target          BPU predicts current group taken
//   req_valid/req_tag/req_index/req_offset   ICache request
//   ps_valid/ps_pc/ps_slot_mask   group presented to IF
//   ps_ex/ps_exccode              AdEL flag and exception code
//   drop_resp                     IF discards the next ICache response
//   redirect_cnt/bpu_taken_cnt    performance counters

module prefetch_pc_gen #(
    parameter int          FETCH_WIDTH = 2,
    parameter logic [31:0] RESET_PC    = 32'hBFC0_0000,
    parameter logic [31:0] EX_PC       = 32'hBFC0_0380,
    parameter int          PERF_EN     = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fs_allowin,
    input  logic                   icache_busy,
    input  logic                   eret_valid,
    input  logic [31:0]            eret_pc,
    input  logic                   ex_flush,
    input  logic                   br_redirect,
    input  logic [31:0]            br_target,
    input  logic                   bpu_valid,
    input  logic [31:0]            bpu_target,
    output logic                   req_valid,
    output logic [19:0]            req_tag,
    output logic [7:0]             req_index,
    output logic [3:0]             req_offset,
    output logic                   ps_valid,
    output logic [31:0]            ps_pc,
    output logic [FETCH_WIDTH-1:0] ps_slot_mask,
    output logic                   ps_ex,
    output logic [4:0]             ps_exccode,
    output logic                   drop_resp,
    output logic [31:0]            redirect_cnt,
    output logic [31:0]            bpu_taken_cnt
);

    localparam logic [31:0] GB = 32'(4 * FETCH_WIDTH);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_WAIT   = 2'd1,
        ST_REPLAY = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic        fired_q;

    logic        aligned;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] seq_pc;
    logic [1:0]  slot;
    logic        req_valid_c;
    logic        drop_c;
    logic        advance;

    assign aligned  = (pc[1:0] == 2'b00);
    assign redirect = eret_valid | ex_flush | br_redirect;
    assign seq_pc   = (pc & ~(GB - 32'd1)) + GB;

    always_comb begin
        redirect_pc = br_target;
        if (eret_valid)
            redirect_pc = eret_pc;
        else if (ex_flush)
            redirect_pc = EX_PC;
    end

    // Slot index within the group; always 0 for single-wide fetch.
    assign slot = 2'((pc >> 2) & 32'(FETCH_WIDTH - 1));

    always_comb begin
        ps_slot_mask = '0;
        if (!aligned) begin
            ps_slot_mask[0] = 1'b1;
        end else begin
            for (int i = 0; i < FETCH_WIDTH; i++)
                ps_slot_mask[i] = (i >= int'(slot));
        end
    end

    // Request tracking FSM. fired_q remembers that last cycle issued a
    // request, so a busy rising now means that request missed.
    always_comb begin
        state_next  = state;
        req_valid_c = 1'b0;
        drop_c      = 1'b0;
        case (state)
            ST_RUN: begin
                req_valid_c = fs_allowin & ~icache_busy & aligned;
                if (fired_q && icache_busy)
                    state_next = redirect ? ST_REPLAY : ST_WAIT;
            end
            ST_WAIT: begin
                if (redirect)
                    state_next = ST_REPLAY;
                else if (!icache_busy)
                    state_next = ST_RUN;
            end
            ST_REPLAY: begin
                // The replayed request is issued as soon as the miss
                // completes, independent of IF back-pressure.
                if (!icache_busy) begin
                    drop_c      = 1'b1;
                    req_valid_c = aligned;
                    state_next  = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    assign req_valid = req_valid_c & ~reset;
    assign drop_resp = drop_c & ~reset;
    assign advance   = req_valid_c | (~aligned & fs_allowin & (state == ST_RUN));

    // Redirects always update the PC; in WAIT/REPLAY this is the latched PC.
    always_comb begin
        pc_next = pc;
        if (redirect)
            pc_next = redirect_pc;
        else if (advance)
            pc_next = bpu_valid ? bpu_target : seq_pc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_RUN;
            pc      <= RESET_PC;
            fired_q <= 1'b0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            fired_q <= req_valid_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || (PERF_EN == 0)) begin
            redirect_cnt  <= 32'd0;
            bpu_taken_cnt <= 32'd0;
        end else begin
            if (redirect)
                redirect_cnt <= redirect_cnt + 32'd1;
            if (advance && bpu_valid && !redirect)
                bpu_taken_cnt <= bpu_taken_cnt + 32'd1;
        end
    end

    // kseg0/kseg1 map to physical by dropping the top three address bits.
    assign req_tag    = (pc[31:30] == 2'b10) ? {3'b000, pc[28:12]} : pc[31:12];
    assign req_index  = pc[11:4];
    assign req_offset = pc[3:0];

    assign ps_valid   = ~icache_busy & ~reset & (state != ST_WAIT);
    assign ps_pc      = pc;
    assign ps_ex      = ~reset & ~aligned & ~br_redirect;
    assign ps_exccode = ps_ex ? 5'h04 : 5'h1f;

endmodule

// File: doc/prefetch_pc_gen.md
# prefetch_pc_gen

Parametrised pre-fetch PC generator for the superscalar front end. Each cycle it selects the next fetch-group PC from five sources, in priority order: eret, exception, branch redirect, BPU prediction, sequential. It issues a FETCH_WIDTH-slot aligned request to the ICache and tracks requests that are in flight while the ICache is busy, so that a redirect arriving mid-miss discards the stale response. It sits between the BPU/redirect network and the IF stage, and also raises instruction-address exceptions (AdEL) for misaligned PCs.

## Interface
- FETCH_WIDTH, 2, instructions per fetch group; legal values 1, 2, 4.
- RESET_PC, 32'hBFC0_0000, PC after reset.
- EX_PC, 32'hBFC0_0380, general exception vector.
- PERF_EN, 0, when 1 the redirect counters are enabled; when 0 they are held at 0.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- fs_allowin  in  1  IF stage can accept a group.
- icache_busy  in  1  ICache is servicing a miss or refill.
- eret_valid / eret_pc  in  1 / 32  eret commit and its target (EPC).
- ex_flush  in  1  exception commit; target is EX_PC.
- br_redirect / br_target  in  1 / 32  branch misprediction from EX and the corrected PC.
- bpu_valid / bpu_target  in  1 / 32  BPU predicts the current group taken.
- req_valid  out  1  ICache request strobe.
- req_tag  out  20  physical tag.
- req_index  out  8  equals pc[11:4].
- req_offset  out  4  equals pc[3:0].
- ps_valid  out  1  group presented to IF.
- ps_pc  out  32  group start PC.
- ps_slot_mask  out  FETCH_WIDTH  valid slots in the group.
- ps_ex / ps_exccode  out  1 / 5  AdEL flag; exccode 5'h04 when set, else 5'h1f.
- drop_resp  out  1  one-cycle pulse: IF discards the next ICache response.
- redirect_cnt / bpu_taken_cnt  out  32 / 32  performance counters; wrap at 2^32.

## Operation
- GB = 4*FETCH_WIDTH bytes. The slot index is s = pc[log2(FETCH_WIDTH)+1:2]; it is 0 when FETCH_WIDTH=1.
- The sequential next PC is (pc & ~(GB-1)) + GB. Groups never cross a GB boundary.
- ps_slot_mask sets bits s .. FETCH_WIDTH-1. On AdEL only bit 0 is set.
- Next-PC priority: eret_valid → eret_pc; ex_flush → EX_PC; br_redirect → br_target; bpu_valid → bpu_target; otherwise sequential.
- The PC update is taken unconditionally on eret_valid, ex_flush or br_redirect. Otherwise the PC updates only on advance.
- Advance = fire, or (misaligned and fs_allowin and state RUN).
- Physical tag:
  - pc[31:30]==2'b10 (kseg0/kseg1): req_tag = {3'b000, pc[28:12]}.
  - Otherwise: req_tag = pc[31:12].
- Misaligned means pc[1:0] != 0. A misaligned PC never raises req_valid. It is presented with ps_ex=1, except that ps_ex is forced to 0 in any cycle where br_redirect=1.
- States:
  - RUN: req_valid = fs_allowin & ~icache_busy & aligned. fire = req_valid. On fire, if icache_busy rises next cycle, go to WAIT.
  - WAIT: req_valid=0. icache_busy falling → RUN. A redirect (eret/ex/br) → REPLAY, with the new PC latched.
  - REPLAY: req_valid=0 while busy. When icache_busy falls: pulse drop_resp, drive req_valid=1 for the latched PC regardless of fs_allowin (held as an outstanding request), then → RUN.
  - A further redirect while in REPLAY overwrites the latched PC. Priority still applies among same-cycle sources.
- ps_valid = ~icache_busy & ~reset & (state != WAIT).
- Counters (PERF_EN=1):
  - redirect_cnt increments per cycle with any of eret_valid, ex_flush, br_redirect.
  - bpu_taken_cnt increments per advance with bpu_valid and no redirect.

## Timing
- Reset values: pc=RESET_PC, state RUN, req_valid=0, ps_valid=0, drop_resp=0, ps_ex=0, counters 0.
- The first request is made in the first cycle after reset deasserts, provided fs_allowin=1 and icache_busy=0.
- Redirect at cycle t with the ICache idle: req_pc = target at t+1 (one-cycle latency).
- Redirect during WAIT: drop_resp and the replayed request occur in the same cycle, namely the first cycle with icache_busy=0.
- Simultaneous eret_valid and ex_flush: eret wins. Simultaneous br_redirect and bpu_valid: br_redirect wins, and bpu_taken_cnt does not count.
- Reset asserted mid-WAIT or mid-REPLAY: the latched PC is discarded, state returns to RUN, and no drop_resp is issued.
- The sequential increment wraps 0xFFFF_FFF0 + GB modulo 2^32.

## Test plan
- Reset, FETCH_WIDTH=2, fs_allowin=1 → req_pc 0xBFC00000, then 0xBFC00008 and 0xBFC00010; req_tag 0x1FC00; mask 2'b11.
- BPU target 0x8000_0104 (s=1) → mask 2'b10, req_tag 0x00000; next PC 0x8000_0108.
- icache_busy high for 5 cycles with br_redirect to 0x8000_0200 in cycle 2 → no req_valid while busy. On the first idle cycle: drop_resp=1, req_valid=1, req_pc 0x8000_0200.
- Same cycle eret_valid (EPC 0x8000_0040), ex_flush and br_redirect → next PC 0x8000_0040; redirect_cnt +1.
- br_target 0x8000_0102 → req_valid=0, ps_ex=1, exccode 5'h04, mask 2'b01. A br_redirect in that same cycle forces ps_ex=0.
- FETCH_WIDTH=4, PC 0x8000_0FF8 → mask 4'b1100, next PC 0x8000_1000, req_index wraps to 0x00.
